// File: rtl/bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_2m
// Purpose  : Two-master to one-slave bus arbiter with a combinational grant.
//            It uses fixed m0 priority, an anti-starvation override for m1,
//            and holds ownership while the slave stalls.
//            Optional contention counters are enabled by BUS_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_2m #(
    parameter int unsigned STARVE_LIMIT   = 8,
    parameter int unsigned PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [31:0]               m0_address_i,
    input  logic                      m0_read_i,
    input  logic                      m0_write_i,
    input  logic [31:0]               m0_data_wr_i,
    input  logic [3:0]                m0_mask_i,
    output logic                      m0_stall_o,
    output logic [31:0]               m0_data_rd_o,
    output logic [31:0]               m0_data_rd_2_o,
    output logic [5:0]                m0_interrupt_o,

    input  logic [31:0]               m1_address_i,
    input  logic                      m1_read_i,
    input  logic                      m1_write_i,
    input  logic [31:0]               m1_data_wr_i,
    input  logic [3:0]                m1_mask_i,
    output logic                      m1_stall_o,
    output logic [31:0]               m1_data_rd_o,
    output logic [31:0]               m1_data_rd_2_o,
    output logic [5:0]                m1_interrupt_o,

    output logic [31:0]               s_address_o,
    output logic                      s_read_o,
    output logic                      s_write_o,
    output logic [31:0]               s_data_wr_o,
    output logic [3:0]                s_mask_o,
    input  logic                      s_stall_i,
    input  logic [31:0]               s_data_rd_i,
    input  logic [31:0]               s_data_rd_2_i,
    input  logic [5:0]                s_interrupt_i,

    output logic [1:0]                owner_o,
    output logic [PERF_CNT_WIDTH-1:0] contend_cnt_o,
    output logic [PERF_CNT_WIDTH-1:0] starve_evt_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;

    logic req0, req1;
    logic sel0, sel1;
    logic starve_hit;
    logic done0, done1;

    assign req0       = m0_read_i | m0_write_i;
    assign req1       = m1_read_i | m1_write_i;
    assign starve_hit = (starve_cnt_q == STARVE_MAX);

    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        case (state_q)
            HOLD0: sel0 = 1'b1;
            HOLD1: sel1 = 1'b1;
            default: begin
                if (req0 && req1) begin
                    sel1 = starve_hit;
                    sel0 = !starve_hit;
                end else begin
                    sel0 = req0;
                    sel1 = req1;
                end
            end
        endcase
    end

    assign done0 = sel0 && req0 && !s_stall_i;
    assign done1 = sel1 && req1 && !s_stall_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel0 && req0 && s_stall_i)
                    state_d = HOLD0;
                else if (sel1 && req1 && s_stall_i)
                    state_d = HOLD1;
            end
            // A master dropping its request mid-hold also releases the bus
            HOLD0:   if (!req0 || !s_stall_i) state_d = IDLE;
            HOLD1:   if (!req1 || !s_stall_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req1 || done1)
            starve_cnt_d = 8'd0;
        else if (done0 && !starve_hit)
            starve_cnt_d = starve_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        s_address_o = 32'd0;
        s_read_o    = 1'b0;
        s_write_o   = 1'b0;
        s_data_wr_o = 32'd0;
        s_mask_o    = 4'd0;
        if (sel0) begin
            s_address_o = m0_address_i;
            s_read_o    = m0_read_i;
            s_write_o   = m0_write_i;
            s_data_wr_o = m0_data_wr_i;
            s_mask_o    = m0_mask_i;
        end else if (sel1) begin
            s_address_o = m1_address_i;
            s_read_o    = m1_read_i;
            s_write_o   = m1_write_i;
            s_data_wr_o = m1_data_wr_i;
            s_mask_o    = m1_mask_i;
        end
    end

    assign m0_stall_o = sel0 ? s_stall_i : req0;
    assign m1_stall_o = sel1 ? s_stall_i : req1;
    assign owner_o    = {sel1, sel0};

    assign m0_data_rd_o   = s_data_rd_i;
    assign m0_data_rd_2_o = s_data_rd_2_i;
    assign m0_interrupt_o = s_interrupt_i;
    assign m1_data_rd_o   = s_data_rd_i;
    assign m1_data_rd_2_o = s_data_rd_2_i;
    assign m1_interrupt_o = s_interrupt_i;

`ifdef BUS_ARB_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] contend_cnt_q;
    logic [PERF_CNT_WIDTH-1:0] starve_evt_cnt_q;
    logic                      contend;
    logic                      forced_m1;

    assign contend   = (sel0 && req1) || (sel1 && req0);
    assign forced_m1 = (state_q == IDLE) && req0 && req1 && starve_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contend_cnt_q    <= '0;
            starve_evt_cnt_q <= '0;
        end else begin
            if (contend)
                contend_cnt_q <= contend_cnt_q + PERF_CNT_WIDTH'(1);
            if (forced_m1)
                starve_evt_cnt_q <= starve_evt_cnt_q + PERF_CNT_WIDTH'(1);
        end
    end

    assign contend_cnt_o    = contend_cnt_q;
    assign starve_evt_cnt_o = starve_evt_cnt_q;
`else
    assign contend_cnt_o    = '0;
    assign starve_evt_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_2m
// Purpose  : Directed-vector scoreboard bench for bus_arbiter_2m (STARVE_LIMIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_2m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_address, m0_data_wr, m1_address, m1_data_wr;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_stall, m1_stall;
    logic [31:0] m0_data_rd, m0_data_rd_2, m1_data_rd, m1_data_rd_2;
    logic [5:0]  m0_interrupt, m1_interrupt;
    logic [31:0] s_address, s_data_wr;
    logic        s_read, s_write;
    logic [3:0]  s_mask;
    logic        s_stall = 1'b0;
    logic [31:0] s_data_rd = 32'd0, s_data_rd_2 = 32'd0;
    logic [5:0]  s_interrupt = 6'd0;
    logic [1:0]  owner;
    logic [31:0] contend_cnt, starve_evt_cnt;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.STARVE_LIMIT(4), .PERF_CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_address_i(m0_address), .m0_read_i(m0_read), .m0_write_i(m0_write),
        .m0_data_wr_i(m0_data_wr), .m0_mask_i(m0_mask), .m0_stall_o(m0_stall),
        .m0_data_rd_o(m0_data_rd), .m0_data_rd_2_o(m0_data_rd_2), .m0_interrupt_o(m0_interrupt),
        .m1_address_i(m1_address), .m1_read_i(m1_read), .m1_write_i(m1_write),
        .m1_data_wr_i(m1_data_wr), .m1_mask_i(m1_mask), .m1_stall_o(m1_stall),
        .m1_data_rd_o(m1_data_rd), .m1_data_rd_2_o(m1_data_rd_2), .m1_interrupt_o(m1_interrupt),
        .s_address_o(s_address), .s_read_o(s_read), .s_write_o(s_write),
        .s_data_wr_o(s_data_wr), .s_mask_o(s_mask), .s_stall_i(s_stall),
        .s_data_rd_i(s_data_rd), .s_data_rd_2_i(s_data_rd_2), .s_interrupt_i(s_interrupt),
        .owner_o(owner), .contend_cnt_o(contend_cnt), .starve_evt_cnt_o(starve_evt_cnt)
    );

    typedef struct {
        int          idx;
        logic [1:0]  own;
        logic [31:0] addr, wd, rd, rd2;
        logic        rd_en, wr_en, st0, st1;
        logic [3:0]  mask;
        logic [5:0]  irq;
        logic [31:0] cc, ec;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   vidx   = 0;

    function automatic logic [31:0] perf(input int v);
`ifdef BUS_ARB_PERF_EN
        return 32'(v);
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
        end
    endtask

    // Apply one vector just after a rising edge and queue the hand-derived response.
    task automatic step(input logic a0r, a0w, a1r, a1w, sst, rp,
                        input logic [1:0] eown, input logic e0, e1,
                        input int ecc, eec);
        exp_t e;
        @(posedge clk);
        #1;
        m0_read = a0r; m0_write = a0w; m1_read = a1r; m1_write = a1w; s_stall = sst;
        s_data_rd   = $urandom;
        s_data_rd_2 = $urandom;
        s_interrupt = 6'($urandom_range(0, 63));
        if (rp) begin
            #1;
            rst = 1'b1;
        end
        e.idx = vidx; vidx++;
        e.own = eown; e.st0 = e0; e.st1 = e1;
        e.addr = 32'd0; e.wd = 32'd0; e.mask = 4'd0; e.rd_en = 1'b0; e.wr_en = 1'b0;
        if (eown == 2'b01) begin
            e.addr = m0_address; e.wd = m0_data_wr; e.mask = m0_mask; e.rd_en = a0r; e.wr_en = a0w;
        end else if (eown == 2'b10) begin
            e.addr = m1_address; e.wd = m1_data_wr; e.mask = m1_mask; e.rd_en = a1r; e.wr_en = a1w;
        end
        e.rd = s_data_rd; e.rd2 = s_data_rd_2; e.irq = s_interrupt;
        e.cc = perf(ecc); e.ec = perf(eec);
        q.push_back(e);
        if (rp) begin
            @(negedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk(e.idx, "owner",      32'(owner),    32'(e.own));
                chk(e.idx, "s_address",  s_address,     e.addr);
                chk(e.idx, "s_read",     32'(s_read),   32'(e.rd_en));
                chk(e.idx, "s_write",    32'(s_write),  32'(e.wr_en));
                chk(e.idx, "s_data_wr",  s_data_wr,     e.wd);
                chk(e.idx, "s_mask",     32'(s_mask),   32'(e.mask));
                chk(e.idx, "m0_stall",   32'(m0_stall), 32'(e.st0));
                chk(e.idx, "m1_stall",   32'(m1_stall), 32'(e.st1));
                chk(e.idx, "m0_data_rd", m0_data_rd,    e.rd);
                chk(e.idx, "m1_data_rd_2", m1_data_rd_2, e.rd2);
                chk(e.idx, "m1_data_rd", m1_data_rd,    e.rd);
                chk(e.idx, "m0_data_rd_2", m0_data_rd_2, e.rd2);
                chk(e.idx, "m0_irq",     32'(m0_interrupt), 32'(e.irq));
                chk(e.idx, "m1_irq",     32'(m1_interrupt), 32'(e.irq));
                chk(e.idx, "contend_cnt", contend_cnt,  e.cc);
                chk(e.idx, "starve_evt_cnt", starve_evt_cnt, e.ec);
            end
        end
    end

    initial begin : driver
        m0_address = 32'h8000_0010; m0_data_wr = 32'hA5A5_0001; m0_mask = 4'hF;
        m1_address = 32'h0000_2004; m1_data_wr = 32'h5A5A_0002; m1_mask = 4'h3;
        //    0r 0w 1r 1w st rp  own    s0 s1  cc  ec
        step(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);   // reset state
        step(1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);   // lone m0 read
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0);   // contention, m0 held
        step(0, 1, 1, 0, 1, 0, 2'b01, 1, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, 2'b01, 0, 1, 2, 0);
        step(0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 3, 0);   // m1 next, no bubble
        step(0, 0, 1, 0, 1, 0, 2'b10, 0, 1, 3, 0);   // m1 enters HOLD1
        step(1, 0, 1, 0, 1, 0, 2'b10, 1, 1, 3, 0);
        step(1, 0, 1, 0, 0, 0, 2'b10, 1, 0, 4, 0);
        step(1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 5, 0);
        step(1, 0, 1, 0, 0, 0, 2'b01, 0, 1, 5, 0);   // starvation run
        step(1, 0, 1, 0, 0, 0, 2'b01, 0, 1, 6, 0);
        step(1, 0, 1, 0, 0, 0, 2'b01, 0, 1, 7, 0);
        step(1, 0, 1, 0, 0, 0, 2'b01, 0, 1, 8, 0);
        step(1, 0, 1, 0, 0, 0, 2'b10, 1, 0, 9, 0);   // forced m1 grant
        step(1, 0, 1, 0, 0, 0, 2'b01, 0, 1, 10, 1);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 11, 1);
        step(0, 0, 1, 0, 1, 0, 2'b10, 0, 1, 11, 1);  // HOLD1, then async reset
        step(0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0);   // m1 reissues from IDLE
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 2'b01, 1, 0, 0, 0);   // HOLD0, then m0 drops
        step(0, 0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Shares one slave-side system bus between two masters.
  - Master 0 (m0) is the data port.
  - Master 1 (m1) is the instruction-fetch port.
- Grant is decided combinationally in the request cycle (zero-latency forwarding).
- Ownership is locked for as long as the slave holds stall.
- Fixed priority to m0, with a saturating anti-starvation counter that forces a grant to m1 after STARVE_LIMIT consecutive m0 wins under contention.
- Sits between the CPU's two memory ports and the address decoder/peripheral mux.

Parameters:
- STARVE_LIMIT, 8: number of consecutive completed m0 transactions with m1 waiting after which m1 wins the next contended arbitration; range 1..255.
- PERF_CNT_WIDTH, 32: width of the optional contention counters.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_address  in  32  master 0 byte address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_data_wr  in  32  master 0 write data
- m0_mask  in  4  master 0 byte mask
- m0_stall  out  1  master 0 must hold its request
- m0_data_rd  out  32  read data to master 0
- m0_data_rd_2  out  32  second read word to master 0
- m0_interrupt  out  6  interrupt lines to master 0
- m1_address, m1_read, m1_write, m1_data_wr, m1_mask, m1_stall, m1_data_rd, m1_data_rd_2, m1_interrupt: identical set for master 1
- s_address  out  32  to slave
- s_read  out  1  to slave
- s_write  out  1  to slave
- s_data_wr  out  32  to slave
- s_mask  out  4  to slave
- s_stall  in  1  slave busy
- s_data_rd  in  32  slave read data
- s_data_rd_2  in  32  slave second read word
- s_interrupt  in  6  slave interrupt lines
- owner  out  2  one-hot current selection: bit0 = m0, bit1 = m1, 00 = none
- contend_cnt  out  PERF_CNT_WIDTH  cycles in which the non-selected master was stalled by arbitration
- starve_evt_cnt  out  PERF_CNT_WIDTH  number of forced m1 grants

Behaviour:
- Request: reqN = mN_read | mN_write.
- States: IDLE, HOLD0, HOLD1 (2-bit register). Starvation counter starve_cnt: 8 bits, saturating at STARVE_LIMIT.
- Selection (combinational):
  - HOLD0 selects m0; HOLD1 selects m1.
  - IDLE with only one master requesting selects that master.
  - IDLE with both requesting selects m1 if starve_cnt == STARVE_LIMIT, otherwise m0.
  - No request selects none.
- Slave outputs: the selected master's address, read, write, data_wr and mask, unmodified. With no selection, all slave outputs are 0.
- Master stall:
  - Selected master: mN_stall = s_stall.
  - Non-selected master: mN_stall = reqN (1 while it requests, 0 otherwise).
- Return paths: s_data_rd, s_data_rd_2 and s_interrupt go to both masters unconditionally. The interrupt is never gated.
- Completion is a cycle with the selected master requesting and s_stall = 0.
- Transitions:
  - IDLE -> HOLDx when the selected master x requests and s_stall = 1.
  - HOLDx -> IDLE when s_stall = 0 (the completion cycle).
  - HOLDx -> IDLE also when master x drops its request (protocol violation); the slave sees an idle bus that cycle.
  - Back-to-back: after a completion, the next cycle re-arbitrates from IDLE. No bubble cycle.
- starve_cnt updates on each clock edge:
  - Increments, saturating, on an m0 completion while req1 = 1.
  - Clears on an m1 completion, or in any cycle with req1 = 0.
  - Otherwise holds.
- Reset (asynchronous): state = IDLE, starve_cnt = 0, counters = 0. Outputs follow combinationally from IDLE, so any in-flight transaction is dropped and the master must reissue.
- Simultaneous events:
  - A forced-m1 win and m0 completion never coincide (only one master is selected per cycle).
  - Reset during HOLDx overrides stall.

Optional Feature:
- Macro BUS_ARB_PERF_EN.
- Defined:
  - contend_cnt increments, wrapping, each cycle in which a non-selected master requests.
  - starve_evt_cnt increments, wrapping, each IDLE cycle in which m1 wins because starve_cnt == STARVE_LIMIT.
  - Both counters clear on rst.
- Undefined: both outputs are constant 0 and no counter flops are synthesised. Arbitration behaviour is identical in both builds.

Test Plan:
- m0 read of 0x8000_0010, mask 1111, s_stall = 0, m1 idle -> same cycle: s_address = 0x8000_0010, s_read = 1, owner = 01, m0_stall = 0, m1_stall = 0; state stays IDLE.
- m0 write and m1 read both asserted, s_stall high for 2 cycles then low -> m0 owns for 3 cycles (HOLD0), m1_stall = 1 throughout, contend_cnt = 3; cycle 4: owner = 10, s_address = m1_address.
- m1 in HOLD1 (s_stall = 1), m0 raises read -> owner stays 10 and m0_stall = 1 until the first s_stall = 0 cycle; m0 granted the next cycle.
- STARVE_LIMIT = 4, both masters request continuously, s_stall = 0 -> m0 completes cycles 1-4, m1 selected cycle 5 (starve_evt_cnt = 1), starve_cnt returns to 0, m0 selected cycle 6.
- rst pulsed asynchronously mid-HOLD1 -> owner and slave outputs go to 0 before the next edge; after release, m1 reissues and is granted from IDLE.
- Build without BUS_ARB_PERF_EN, rerun contention scenario -> contend_cnt = 0 and starve_evt_cnt = 0 every cycle; grant sequence identical to the enabled build.
